// File: rtl/parity_frame_pkg.sv
// parity_frame_pkg: shared FSM states and frame-format constants for the serial parity receiver
package parity_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int   DATA_BITS = 4;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit with a selectable reset level
// Ports: clk, rst (async, active high), d (async input), q (synchronized output)
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/even_parity_frame_receiver.sv
// even_parity_frame_receiver: recovers start/4 data/parity/stop frames from a serial line
// Ports: clk, rst (async, active high), sin (serial line, idles high);
//        a..d (data bits in line order), p (parity bit), frame_valid / frame_err (one-cycle
//        strobes for a good / badly framed frame), busy (receiver not idle)
module even_parity_frame_receiver
    import parity_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sin,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic p,
    output logic frame_valid,
    output logic frame_err,
    output logic busy
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    LAST_IDX = 2'(DATA_BITS - 1);

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [1:0]           idx, idx_n;
    // shadow[DATA_BITS] is parity, shadow[i] is the i-th data bit on the line
    logic [DATA_BITS:0]   shadow, shadow_n;
    logic [DATA_BITS:0]   word;
    logic                 sin_s, sin_s_d;
    logic                 valid_n, err_n;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sin),
        .q   (sin_s)
    );

    assign {p, d, c, b, a} = word;
    assign busy = (state != IDLE);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        shadow_n = shadow;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (sin_s_d && !sin_s)
                    state_n = START;
            end
            START: begin
                // mid-bit recheck rejects glitches shorter than half a bit
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = (sin_s == START_LVL) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n       = '0;
                    shadow_n[idx] = sin_s;
                    idx_n       = idx + 2'd1;
                    if (idx == LAST_IDX)
                        state_n = PARITY;
                end
            end
            PARITY: begin
                if (cnt == LAST) begin
                    cnt_n               = '0;
                    shadow_n[DATA_BITS] = sin_s;
                    state_n             = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    valid_n = (sin_s == STOP_LVL);
                    err_n   = (sin_s != STOP_LVL);
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shadow      <= '0;
            word        <= '0;
            sin_s_d     <= 1'b1;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shadow      <= shadow_n;
            word        <= valid_n ? shadow : word;
            sin_s_d     <= sin_s;
            frame_valid <= valid_n;
            frame_err   <= err_n;
        end
    end

endmodule

// File: tb/tb_even_parity_frame_receiver.sv
// tb_even_parity_frame_receiver: scoreboard bench for the serial parity frame receiver
module tb_even_parity_frame_receiver;

    localparam int N = 4;
    // drive-to-strobe latency: 2 sync cycles, edge detect, half bit, six bits, output register
    localparam int LAT = 3 + N / 2 + 6 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sin = 1'b1;
    logic a, b, c, d, p, frame_valid, frame_err, busy;

    even_parity_frame_receiver #(.CLKS_PER_BIT(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .sin         (sin),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .p           (p),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit         err;
        logic [4:0] bits;
        int         at;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] held = '0;
    int         checks = 0;
    int         passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive(input logic v, input int len);
        sin = v;
        repeat (len) @(negedge clk);
    endtask

    // dat[3] is the first data bit on the line (a)
    task automatic frame(input logic [3:0] dat, input logic par, input logic stp, input int stop_len);
        exp_t e;
        if (stp) held = {dat, par};
        e.err  = !stp;
        e.bits = held;
        e.at   = cyc + LAT;
        sb.push_back(e);
        drive(1'b0, N);
        for (int i = 3; i >= 0; i--) drive(dat[i], N);
        drive(par, N);
        drive(stp, stop_len);
    endtask

    always @(negedge clk) begin
        if (!rst && (frame_valid || frame_err)) begin
            check("exclusive", frame_valid & frame_err, 1'b0);
            check("pulse_expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("kind_err", frame_err, e.err);
                check("outputs", {a, b, c, d, p}, e.bits);
                check("strobe_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        int c0;
        logic [3:0] rd;
        logic rp, rs;
        repeat (3) @(negedge clk);
        check("reset_outs", {a, b, c, d, p, frame_valid, frame_err, busy}, 8'h00);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        frame(4'b1011, 1'b1, 1'b1, N);
        drive(1'b1, 8);

        c0 = cyc;
        sin = 1'b0;
        @(negedge clk);
        sin = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_hi", busy, 1'b1);
        check("glitch_cycle", cyc, c0 + 3);
        repeat (3) @(negedge clk);
        check("glitch_busy_lo", busy, 1'b0);
        drive(1'b1, 10);

        frame(4'b1100, 1'b0, 1'b1, N);
        frame(4'b0111, 1'b1, 1'b0, N);
        drive(1'b1, N);

        frame(4'b0001, 1'b1, 1'b1, N - 1);
        frame(4'b1111, 1'b0, 1'b1, N);
        drive(1'b1, 30);
        check("drained_mid", sb.size(), 0);

        drive(1'b0, N);
        drive(1'b1, N);
        drive(1'b0, N);
        drive(1'b1, 2);
        check("busy_in_data", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("async_reset_outs", {a, b, c, d, p, frame_valid, frame_err, busy}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        held = '0;
        drive(1'b1, 10);
        check("post_reset_outs", {a, b, c, d, p}, 5'h00);
        frame(4'b1010, 1'b0, 1'b1, N);
        drive(1'b1, 2);

        for (int k = 0; k < 20; k++) begin
            rd = 4'($urandom);
            rp = 1'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            frame(rd, rp, rs, N);
            drive(1'b1, rs ? $urandom_range(0, 6) : $urandom_range(1, 6));
        end

        for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
        check("drained_end", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
